// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// With IF_MISALIGN_EN defined the FSM gains the S_HALT state.
package cpu_pkg;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

`ifdef IF_MISALIGN_EN
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } if_state_e;
`else
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } if_state_e;
`endif

endpackage

// File: rtl/if_pc_reg.sv
// Fetch PC register: reset value, word-aligned redirect load, and +4 increment (mod 2^32).
module if_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_load,
    input  logic [31:2] i_load_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_inc
);

    logic [31:0] r_pc;

    // A redirect load wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= {i_load_pc, 2'b00};
        end else if (i_inc) begin
            r_pc <= o_pc_inc;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_inc = r_pc + PC_INC;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, single-entry output slot,
// redirect flush with stale-response drain. IF_MISALIGN_EN adds if_misalign and S_HALT.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid,
`ifdef IF_MISALIGN_EN
    output logic        if_misalign,
`endif
    output if_state_e   dbg_state
);

    // Handshake: a request transfers on a cycle with imem_req & imem_ready; exactly one
    // imem_rvalid pulse follows each transfer; the slot is consumed on if_valid & !stall.

    if_state_e   r_state, w_state_nxt;
    logic [31:0] w_fetch_pc, w_fetch_pc_inc;
    logic        r_valid;
    logic [31:0] r_pc, r_pc4, r_inst;
    logic        w_req, w_accept, w_consume, w_load_slot, w_pc_inc, w_flush;

`ifdef IF_MISALIGN_EN
    logic        r_misalign, r_fault_pend, w_fault_pend_nxt, w_fault_load, w_redir_mis;
    logic [31:0] r_fault_pc, w_fault_pc;

    assign w_redir_mis = redirect & (redirect_pc[1:0] != 2'b00);
    assign w_fault_pc  = redirect ? redirect_pc : r_fault_pc;
`else
    logic w_unused;
    assign w_unused = ^{redirect_pc[1:0], NOP_INST};
`endif

    assign w_accept  = w_req & imem_ready;
    assign w_consume = r_valid & ~stall;
    assign w_flush   = redirect;

    if_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_inc     (w_pc_inc),
        .i_load    (redirect),
        .i_load_pc (redirect_pc[31:2]),
        .o_pc      (w_fetch_pc),
        .o_pc_inc  (w_fetch_pc_inc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_load_slot = 1'b0;
        w_pc_inc    = 1'b0;
`ifdef IF_MISALIGN_EN
        w_fault_load     = 1'b0;
        w_fault_pend_nxt = r_fault_pend;
`endif
        case (r_state)
            S_REQ: begin
                w_req = rst_n & ~(r_valid & stall);
                if (redirect) begin
                    w_state_nxt = w_accept ? S_DRAIN : S_REQ;
                end else if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    w_load_slot = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                // A response arriving with a fresh redirect still retires the stale request.
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
`ifdef IF_MISALIGN_EN
            S_HALT: begin
                if (redirect) begin
                    w_state_nxt = S_REQ;
                end
            end
`endif
            default: w_state_nxt = S_REQ;
        endcase
`ifdef IF_MISALIGN_EN
        // The fault slot is loaded only once nothing is outstanding, then fetch halts.
        if (redirect) begin
            w_fault_pend_nxt = w_redir_mis;
        end
        if (w_fault_pend_nxt && (w_state_nxt == S_REQ)) begin
            w_fault_load     = 1'b1;
            w_fault_pend_nxt = 1'b0;
            w_state_nxt      = S_HALT;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= '0;
        end else begin
            if (w_flush) begin
                r_valid <= 1'b0;
            end else if (w_load_slot) begin
                r_valid <= 1'b1;
                r_pc    <= w_fetch_pc;
                r_pc4   <= w_fetch_pc_inc;
                r_inst  <= imem_rdata;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
`ifdef IF_MISALIGN_EN
            if (w_fault_load) begin
                r_valid <= 1'b1;
                r_pc    <= w_fault_pc;
                r_pc4   <= w_fault_pc + PC_INC;
                r_inst  <= NOP_INST;
            end
`endif
        end
    end

`ifdef IF_MISALIGN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign   <= 1'b0;
            r_fault_pend <= 1'b0;
            r_fault_pc   <= '0;
        end else begin
            r_fault_pend <= w_fault_pend_nxt;
            if (w_redir_mis) begin
                r_fault_pc <= redirect_pc;
            end
            if (w_fault_load) begin
                r_misalign <= 1'b1;
            end else if (w_flush | w_load_slot | w_consume) begin
                r_misalign <= 1'b0;
            end
        end
    end

    assign if_misalign = r_misalign;
`endif

    assign imem_req  = w_req;
    assign imem_addr = w_fetch_pc;
    assign if_pc     = r_pc;
    assign if_pc4    = r_pc4;
    assign if_inst   = r_inst;
    assign if_valid  = r_valid;
    assign dbg_state = r_state;

endmodule
